// File: rtl/kernel_button_debounce_pkg.sv
// Shared debounce definitions: channel state encoding
// and counter-width helper.
package kernel_button_debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Counter width never collapses below one bit.
  function automatic int cnt_width(input int v);
    int w;
    w = clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/kernel_debounce_cell.sv
// One button channel: 2-flop synchroniser, stability
// counter, clean level register and edge pulses.
module kernel_debounce_cell
  import kernel_button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_debounced,
  output logic o_press,
  output logic o_release,
  output logic o_busy
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_deb;
  logic             r_press;
  logic             r_rel;

  state_e           w_state;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_deb_nxt;
  logic             w_press_nxt;
  logic             w_rel_nxt;

  // Synchronise the pin; polarity folded in at s1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw ^ ACTIVE_LOW;
      r_s2 <= r_s1;
    end
  end

  // Qualify: count while s2 disagrees, accept at terminal.
  always_comb begin
    w_state     = (r_s2 != r_deb) ? ST_COUNT
                                  : ST_STABLE;
    w_cnt_nxt   = '0;
    w_deb_nxt   = r_deb;
    w_press_nxt = 1'b0;
    w_rel_nxt   = 1'b0;
    unique case (w_state)
      ST_STABLE: begin
        w_cnt_nxt = '0;
      end
      ST_COUNT: begin
        if (r_cnt == TERM) begin
          w_cnt_nxt   = '0;
          w_deb_nxt   = r_s2;
          w_press_nxt = r_s2;
          w_rel_nxt   = ~r_s2;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // Counter, level and pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_deb   <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_deb   <= w_deb_nxt;
      r_press <= w_press_nxt;
      r_rel   <= w_rel_nxt;
    end
  end

  assign o_debounced = r_deb;
  assign o_press     = r_press;
  assign o_release   = r_rel;
  assign o_busy      = r_s2 != r_deb;

endmodule

// File: rtl/kernel_button_debounce.sv
// Multi-channel button conditioner feeding the PIO
// input port; channels are fully independent.
module kernel_button_debounce #(
  parameter int WIDTH         = 1,
  parameter int STABLE_CYCLES = 50000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] button_raw,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] busy
);

  // One conditioning cell per button.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    kernel_debounce_cell #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_cell (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_raw       (button_raw[g]),
      .o_debounced (debounced[g]),
      .o_press     (press_pulse[g]),
      .o_release   (release_pulse[g]),
      .o_busy      (busy[g])
    );
  end

endmodule

// File: tb/tb_kernel_button_debounce.sv
// Bench for kernel_button_debounce: scenario tasks plus
// a pulse scoreboard checked on every falling edge.
module tb_kernel_button_debounce;

  localparam int W = 2;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] button_raw;
  logic [W-1:0] debounced;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;
  logic [W-1:0] busy;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  kernel_button_debounce #(
    .WIDTH         (W),
    .STABLE_CYCLES (S),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .button_raw    (button_raw),
    .debounced     (debounced),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every pulse must match the queue head.
  always @(negedge clk) begin : mon
    ev_t e;
    if ((press_pulse | release_pulse) != '0) begin
      checks++;
      if ((press_pulse & release_pulse) != '0) begin
        errors++;
        $display("FAIL pulse_overlap cyc=%0d p=%b r=%b",
                 cyc, press_pulse, release_pulse);
      end
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d p=%b r=%b want none",
                 cyc, press_pulse, release_pulse);
      end else begin
        e = q.pop_front();
        checks++;
        if (e.cyc !== cyc || e.press !== press_pulse ||
            e.rel !== release_pulse) begin
          errors++;
          $display("FAIL pulse cyc=%0d p=%b r=%b want cyc=%0d p=%b r=%b",
                   cyc, press_pulse, release_pulse,
                   e.cyc, e.press, e.rel);
        end
      end
    end
  end

  task automatic check_empty(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_pulses got %0d pending want 0",
               name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    button_raw = 2'b00;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({debounced, press_pulse, release_pulse, busy}
          !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold got d=%b p=%b r=%b b=%b want 0",
                 debounced, press_pulse, release_pulse, busy);
      end
    end
    reset_n    = 1'b1;
    button_raw = 2'b11;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({debounced, press_pulse, release_pulse, busy}
          !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle got d=%b p=%b r=%b b=%b want 0",
                 debounced, press_pulse, release_pulse, busy);
      end
    end
  endtask

  task automatic test_clean_press;
    int c;
    c = cyc;
    button_raw = 2'b10;
    q.push_back('{c + 6, 2'b01, 2'b00});
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      checks++;
      if (debounced !== {1'b0, 1'(j >= 6)} ||
          busy !== {1'b0, 1'(j >= 2 && j < 6)}) begin
        errors++;
        $display("FAIL clean_press j=%0d got d=%b b=%b want d=%b b=%b",
                 j, debounced, busy, {1'b0, 1'(j >= 6)},
                 {1'b0, 1'(j >= 2 && j < 6)});
      end
    end
    c = cyc;
    button_raw = 2'b11;
    q.push_back('{c + 6, 2'b00, 2'b01});
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      checks++;
      if (debounced !== {1'b0, 1'(j < 6)}) begin
        errors++;
        $display("FAIL clean_release j=%0d got %b want %b",
                 j, debounced, {1'b0, 1'(j < 6)});
      end
    end
    check_empty("clean_press");
  endtask

  task automatic test_bounce;
    int c;
    c = cyc;
    button_raw = 2'b10;
    q.push_back('{c + 10, 2'b01, 2'b00});
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      checks++;
      if (debounced !== {1'b0, 1'(j >= 10)}) begin
        errors++;
        $display("FAIL bounce j=%0d got %b want %b",
                 j, debounced, {1'b0, 1'(j >= 10)});
      end
      if (j == 3) button_raw = 2'b11;
      if (j == 4) button_raw = 2'b10;
    end
    c = cyc;
    button_raw = 2'b11;
    q.push_back('{c + 6, 2'b00, 2'b01});
    repeat (8) @(negedge clk);
    checks++;
    if (debounced !== 2'b00) begin
      errors++;
      $display("FAIL bounce_release got %b want 00",
               debounced);
    end
    check_empty("bounce");
  endtask

  task automatic test_glitch;
    button_raw = 2'b01;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      checks++;
      if (debounced !== 2'b00 ||
          busy !== {1'(j >= 2 && j <= 4), 1'b0}) begin
        errors++;
        $display("FAIL glitch j=%0d got d=%b b=%b want d=00 b=%b",
                 j, debounced, busy,
                 {1'(j >= 2 && j <= 4), 1'b0});
      end
      if (j == 3) button_raw = 2'b11;
    end
    check_empty("glitch");
  endtask

  task automatic test_simultaneous;
    int c;
    c = cyc;
    button_raw = 2'b00;
    q.push_back('{c + 6, 2'b11, 2'b00});
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      checks++;
      if (debounced !== ((j >= 6) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL sim_press j=%0d got %b", j, debounced);
      end
    end
    c = cyc;
    button_raw = 2'b11;
    q.push_back('{c + 6, 2'b00, 2'b11});
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      checks++;
      if (debounced !== ((j >= 6) ? 2'b00 : 2'b11)) begin
        errors++;
        $display("FAIL sim_release j=%0d got %b", j, debounced);
      end
    end
    check_empty("simultaneous");
  endtask

  task automatic test_reset_mid_count;
    int c;
    c = cyc;
    button_raw = 2'b10;
    q.push_back('{c + 12, 2'b01, 2'b00});
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      checks++;
      if (debounced !== {1'b0, 1'(j >= 12)} ||
          busy !== {1'b0, 1'((j >= 2 && j <= 4) ||
                             (j >= 8 && j <= 11))}) begin
        errors++;
        $display("FAIL reset_mid j=%0d got d=%b b=%b",
                 j, debounced, busy);
      end
      if (j == 4) reset_n = 1'b0;
      if (j == 6) reset_n = 1'b1;
    end
    button_raw = 2'b11;
    q.push_back('{cyc + 6, 2'b00, 2'b01});
    repeat (8) @(negedge clk);
    check_empty("reset_mid");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
